// File: rtl/xif_copro_issue_queue.sv
// ============================================================================
// xif_copro_issue_queue
// ----------------------------------------------------------------------------
// Issue stage for the XIF coprocessor. It decodes each instruction offered on
// the issue interface, completes the issue handshake with the core, and
// buffers accepted operations in a DEPTH-entry first-word-fall-through FIFO.
// Each entry holds the operation, its operands and its instruction ID, and
// waits there for the execute unit.
//
// Optional feature macro:
//   XIF_COPRO_EXT_OPS_EN - when defined, the decoder also recognises CLZ and
//                          CPOP. When undefined, those encodings are rejected
//                          as non-coprocessor instructions.
//
// Parameters:
//   XLEN     - operand width (power of two, >= 8)
//   DEPTH    - FIFO entries (power of two, >= 2)
//   ID_WIDTH - XIF instruction ID width
//
// Ports:
//   clk_i             in   clock, all state on rising edge
//   rst_i             in   synchronous active-high reset
//   issue_valid_i     in   core offers an instruction
//   issue_ready_o     out  handshake completes when valid && ready
//   issue_instr_i     in   32-bit instruction word
//   issue_id_i        in   instruction ID
//   issue_rs_i        in   {rs[1], rs[0]} source operands
//   issue_rs_valid_i  in   per-operand valid bits
//   issue_accept_o    out  instruction is a coprocessor op (during handshake)
//   issue_writeback_o out  coprocessor will write rd (same as accept)
//   flush_i           in   discard queued and in-handshake operations
//   op_valid_o        out  head entry valid
//   op_ready_i        in   execute unit consumes head
//   op_o              out  head operation (xif_copro_pkg::copro_op_e)
//   op_rs0_o          out  head rs[0]
//   op_rs1_o          out  head shift amount, zero-extended to XLEN
//   op_id_o           out  head instruction ID
//   count_o           out  number of occupied entries
// ============================================================================

package xif_copro_pkg;
    // Operation codes carried through the queue. CLZ and CPOP are only
    // produced when the extended operations are compiled in.
    typedef enum logic [2:0] {
        NONE     = 3'd0,
        BITREV   = 3'd1,
        ROTRIGHT = 3'd2,
        ROTLEFT  = 3'd3,
        CLZ      = 3'd4,
        CPOP     = 3'd5
    } copro_op_e;
endpackage

package xif_copro_instr_pkg;
    // Coprocessor instructions live in the custom-0 opcode space. They are
    // R-type words with funct7 = 0, and funct3 selects the operation. The
    // register fields are don't-care for decode.
    localparam logic [31:0] BITREV   = 32'b0000000_?????_?????_001_?????_0001011;
    localparam logic [31:0] ROTRIGHT = 32'b0000000_?????_?????_010_?????_0001011;
    localparam logic [31:0] ROTLEFT  = 32'b0000000_?????_?????_011_?????_0001011;
    localparam logic [31:0] CLZ      = 32'b0000000_?????_?????_100_?????_0001011;
    localparam logic [31:0] CPOP     = 32'b0000000_?????_?????_101_?????_0001011;
endpackage

module xif_copro_issue_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4,
    localparam int SHW     = $clog2(XLEN),
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [2*XLEN-1:0]   issue_rs_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,

    input  logic                flush_i,

    output logic                op_valid_o,
    input  logic                op_ready_i,
    output logic [2:0]          op_o,
    output logic [XLEN-1:0]     op_rs0_o,
    output logic [XLEN-1:0]     op_rs1_o,
    output logic [ID_WIDTH-1:0] op_id_o,
    output logic [PW-1:0]       count_o
);

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    xif_copro_pkg::copro_op_e dec_op;
    logic                     need_rs0;
    logic                     need_rs1;
    logic                     is_copro;
    logic                     rs_ok;

    logic [XLEN-1:0]          rs0;
    logic [SHW-1:0]           rs1_shamt;
    logic                     unused_rs1_hi;

    assign rs0           = issue_rs_i[XLEN-1:0];
    assign rs1_shamt     = issue_rs_i[XLEN+SHW-1:XLEN];
    // Only the shift-amount bits of rs[1] are ever stored.
    assign unused_rs1_hi = ^issue_rs_i[2*XLEN-1:XLEN+SHW];

    always_comb begin
        dec_op   = xif_copro_pkg::NONE;
        need_rs0 = 1'b0;
        need_rs1 = 1'b0;
        casez (issue_instr_i)
            xif_copro_instr_pkg::BITREV: begin
                dec_op   = xif_copro_pkg::BITREV;
                need_rs0 = 1'b1;
            end
            xif_copro_instr_pkg::ROTRIGHT: begin
                dec_op   = xif_copro_pkg::ROTRIGHT;
                need_rs0 = 1'b1;
                need_rs1 = 1'b1;
            end
            xif_copro_instr_pkg::ROTLEFT: begin
                dec_op   = xif_copro_pkg::ROTLEFT;
                need_rs0 = 1'b1;
                need_rs1 = 1'b1;
            end
`ifdef XIF_COPRO_EXT_OPS_EN
            xif_copro_instr_pkg::CLZ: begin
                dec_op   = xif_copro_pkg::CLZ;
                need_rs0 = 1'b1;
            end
            xif_copro_instr_pkg::CPOP: begin
                dec_op   = xif_copro_pkg::CPOP;
                need_rs0 = 1'b1;
            end
`endif
            default: begin
                dec_op   = xif_copro_pkg::NONE;
            end
        endcase
    end

    assign is_copro = (dec_op != xif_copro_pkg::NONE);
    assign rs_ok    = (!need_rs0 || issue_rs_valid_i[0]) &&
                      (!need_rs1 || issue_rs_valid_i[1]);

    // ------------------------------------------------------------------------
    // FIFO pointers and status
    // ------------------------------------------------------------------------
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // The extra MSB tells a wrapped-around full queue apart from an empty one.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);

    // A non-coprocessor word is rejected immediately, so it never waits on
    // queue space. A coprocessor op needs a free slot and its operands. Full
    // is evaluated before any same-cycle pop, so a slot freed this cycle
    // cannot be reused until the next one.
    assign issue_ready_o     = is_copro ? (!full && rs_ok) : 1'b1;
    assign issue_accept_o    = issue_valid_i && issue_ready_o && is_copro;
    assign issue_writeback_o = issue_accept_o;

    // A flush still lets the handshake complete on the issue side, but the
    // operation is dropped.
    assign push = issue_accept_o && !flush_i;
    assign pop  = !empty && op_ready_i && !flush_i;

    assign count_o = wr_ptr - rd_ptr;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    xif_copro_pkg::copro_op_e op_mem  [DEPTH];
    logic [XLEN-1:0]          rs0_mem [DEPTH];
    logic [SHW-1:0]           rs1_mem [DEPTH];
    logic [ID_WIDTH-1:0]      id_mem  [DEPTH];

    // Pointer and storage update. Reset clears the contents as well as the
    // pointers. Flush only rewinds the pointers, because stale contents
    // are never visible behind an empty queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i]  <= xif_copro_pkg::NONE;
                rs0_mem[i] <= '0;
                rs1_mem[i] <= '0;
                id_mem[i]  <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                op_mem[wr_idx]  <= dec_op;
                rs0_mem[wr_idx] <= rs0;
                // Only the rotates consume rs[1]. Storing zero for the others
                // keeps the head output independent of an unused operand.
                rs1_mem[wr_idx] <= need_rs1 ? rs1_shamt : '0;
                id_mem[wr_idx]  <= issue_id_i;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Head outputs
    // ------------------------------------------------------------------------
    // The head is read straight from storage (fall-through), so it holds
    // steady while stalled. It is forced to zero when the queue is empty.
    assign op_valid_o = !empty;
    assign op_o       = op_valid_o ? op_mem[rd_idx] : xif_copro_pkg::NONE;
    assign op_rs0_o   = op_valid_o ? rs0_mem[rd_idx] : '0;
    assign op_rs1_o   = op_valid_o ? {{(XLEN-SHW){1'b0}}, rs1_mem[rd_idx]} : '0;
    assign op_id_o    = op_valid_o ? id_mem[rd_idx] : '0;

endmodule

// File: tb/tb_xif_copro_issue_queue.sv
// ============================================================================
// tb_xif_copro_issue_queue
// ----------------------------------------------------------------------------
// Self-checking bench for xif_copro_issue_queue.
//
// The driver applies one cycle of stimulus per call and checks the issue-side
// outputs against a reference model. Each accepted operation's expected head
// entry goes onto a scoreboard queue. A separate monitor compares the DUT
// head against the front of that queue whenever op_valid_o is high, and pops
// the entry when it is consumed.
//
// When XIF_COPRO_EXT_OPS_EN is defined, the model also treats CLZ and CPOP
// as coprocessor operations.
// ============================================================================

module tb_xif_copro_issue_queue;
    import xif_copro_pkg::*;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 4;
    localparam int ID_WIDTH = 4;
    localparam int PW       = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [2*XLEN-1:0]   issue_rs_i;
    logic [1:0]          issue_rs_valid_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                flush_i;
    logic                op_valid_o;
    logic                op_ready_i;
    logic [2:0]          op_o;
    logic [XLEN-1:0]     op_rs0_o;
    logic [XLEN-1:0]     op_rs1_o;
    logic [ID_WIDTH-1:0] op_id_o;
    logic [PW-1:0]       count_o;

    typedef struct {
        copro_op_e           op;
        logic [XLEN-1:0]     rs0;
        logic [XLEN-1:0]     rs1;
        logic [ID_WIDTH-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   model_count = 0;
    int   checks      = 0;
    int   fails       = 0;

    always #5 clk = ~clk;

    xif_copro_issue_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs_i        (issue_rs_i),
        .issue_rs_valid_i  (issue_rs_valid_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .flush_i           (flush_i),
        .op_valid_o        (op_valid_o),
        .op_ready_i        (op_ready_i),
        .op_o              (op_o),
        .op_rs0_o          (op_rs0_o),
        .op_rs1_o          (op_rs1_o),
        .op_id_o           (op_id_o),
        .count_o           (count_o)
    );

    // Single comparison point shared by driver and monitor.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference decode: which ops the queue should accept, and what
    // operands they need.
    function automatic bit model_is_copro(input copro_op_e k);
        case (k)
            BITREV, ROTRIGHT, ROTLEFT: return 1'b1;
`ifdef XIF_COPRO_EXT_OPS_EN
            CLZ, CPOP: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_needs_rs1(input copro_op_e k);
        return (k == ROTRIGHT) || (k == ROTLEFT);
    endfunction

    // Build an instruction word for an operation. Register fields are
    // random. NONE produces one of several words outside the coprocessor
    // set, including near misses in custom-0.
    function automatic logic [31:0] make_word(input copro_op_e k);
        logic [4:0] rs2f, rs1f, rdf;
        logic [2:0] f3;
        rs2f = 5'($urandom);
        rs1f = 5'($urandom);
        rdf  = 5'($urandom);
        case (k)
            BITREV:   f3 = 3'd1;
            ROTRIGHT: f3 = 3'd2;
            ROTLEFT:  f3 = 3'd3;
            CLZ:      f3 = 3'd4;
            CPOP:     f3 = 3'd5;
            default:  f3 = 3'd0;
        endcase
        if (k != NONE)
            return {7'b0000000, rs2f, rs1f, f3, rdf, 7'b0001011};
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0013;
            1:       return {7'b0000000, rs2f, rs1f, 3'd6 + 3'($urandom_range(0, 1)), rdf, 7'b0001011};
            2:       return {7'b0100000, rs2f, rs1f, 3'd1, rdf, 7'b0001011};
            default: return {7'b0000000, rs2f, rs1f, 3'($urandom), rdf, 7'b0110011};
        endcase
    endfunction

    // One cycle of stimulus. Inputs are applied just after the rising edge
    // and checked on the falling edge. The model is updated at the next
    // rising edge, where the DUT commits the same cycle.
    task automatic applyStimulus(input logic v, input copro_op_e kind, input logic [31:0] word,
                                 input logic [ID_WIDTH-1:0] id, input logic [XLEN-1:0] r0,
                                 input logic [XLEN-1:0] r1, input logic [1:0] rsv,
                                 input logic rdy, input logic fl, input logic rs);
        bit   copro, exp_ready, exp_accept, do_push, do_pop;
        exp_t ent;
        issue_valid_i    = v;
        issue_instr_i    = word;
        issue_id_i       = id;
        issue_rs_i       = {r1, r0};
        issue_rs_valid_i = rsv;
        op_ready_i       = rdy;
        flush_i          = fl;
        rst_i            = rs;
        @(negedge clk);
        copro      = model_is_copro(kind);
        exp_ready  = copro ? ((model_count < DEPTH) &&
                              (model_needs_rs1(kind) ? (rsv == 2'b11) : rsv[0])) : 1'b1;
        exp_accept = v && exp_ready && copro;
        checkOutput("issue_ready", issue_ready_o, exp_ready);
        checkOutput("issue_accept", issue_accept_o, exp_accept);
        checkOutput("issue_writeback", issue_writeback_o, exp_accept);
        checkOutput("count", count_o, model_count);
        checkOutput("op_valid", op_valid_o, model_count > 0);
        if (model_count == 0) begin
            checkOutput("empty_head_op", op_o, NONE);
            checkOutput("empty_head_fields", {op_rs0_o, op_rs1_o, op_id_o}, 0);
        end
        do_push = exp_accept && !fl && !rs;
        do_pop  = (model_count > 0) && rdy && !fl && !rs;
        ent.op  = kind;
        ent.rs0 = r0;
        ent.rs1 = model_needs_rs1(kind) ? (r1 % XLEN) : '0;
        ent.id  = id;
        @(posedge clk);
        if (rs || fl) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            if (do_push) exp_q.push_back(ent);
            model_count = model_count + int'(do_push) - int'(do_pop);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, NONE, 32'h0000_0013, '0, '0, '0, 2'b00, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compares the head against the oldest expected entry on every
    // cycle it is valid, and pops the entry when it is consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (op_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("head_without_expected_entry", op_valid_o, 1'b0);
                end else begin
                    checkOutput("head_op", op_o, exp_q[0].op);
                    checkOutput("head_rs0", op_rs0_o, exp_q[0].rs0);
                    checkOutput("head_rs1", op_rs1_o, exp_q[0].rs1);
                    checkOutput("head_id", op_id_o, exp_q[0].id);
                    if (op_ready_i && !flush_i && !rst_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        copro_op_e k;
        int        sel;
        logic      rdy;

        rst_i            = 1'b1;
        issue_valid_i    = 1'b0;
        issue_instr_i    = '0;
        issue_id_i       = '0;
        issue_rs_i       = '0;
        issue_rs_valid_i = '0;
        op_ready_i       = 1'b0;
        flush_i          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset released, starting directed sequence");

        // BITREV with only rs[0] valid: accepted, at the head next cycle.
        applyStimulus(1'b1, BITREV, make_word(BITREV), 4'd3, 32'h8000_0001,
                      32'hDEAD_BEEF, 2'b01, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // ROTLEFT stalls until both operands are valid.
        applyStimulus(1'b1, ROTLEFT, make_word(ROTLEFT), 4'd5, 32'h1234_5678,
                      32'h0000_0125, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ROTLEFT, make_word(ROTLEFT), 4'd5, 32'h1234_5678,
                      32'h0000_0125, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Fill, then a blocked copro op and an immediately rejected word.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, ROTRIGHT, make_word(ROTRIGHT), ID_WIDTH'(i), $urandom,
                          $urandom, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ROTRIGHT, make_word(ROTRIGHT), 4'd9, $urandom, $urandom,
                      2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, NONE, 32'h0000_0013, 4'd9, $urandom, $urandom,
                      2'b11, 1'b0, 1'b0, 1'b0);

        // Full with pop: push blocked. Then push and pop together.
        applyStimulus(1'b1, ROTRIGHT, make_word(ROTRIGHT), 4'd4, $urandom, $urandom,
                      2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, ROTRIGHT, make_word(ROTRIGHT), 4'd4, $urandom, $urandom,
                      2'b11, 1'b1, 1'b0, 1'b0);
        repeat (5) idle(1'b1);

        // Flush with a concurrent ROTLEFT: nothing survives.
        applyStimulus(1'b1, BITREV, make_word(BITREV), 4'd1, $urandom, $urandom,
                      2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ROTLEFT, make_word(ROTLEFT), 4'd2, $urandom, $urandom,
                      2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ROTLEFT, make_word(ROTLEFT), 4'd7, $urandom, $urandom,
                      2'b11, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // CLZ: accepted only when the extended ops are built in.
        applyStimulus(1'b1, CLZ, make_word(CLZ), 4'd6, 32'h0000_00FF, $urandom,
                      2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, CPOP, make_word(CPOP), 4'd8, $urandom, $urandom,
                      2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Reset mid-operation with a handshake in flight.
        applyStimulus(1'b1, ROTRIGHT, make_word(ROTRIGHT), 4'd10, $urandom, $urandom,
                      2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ROTRIGHT, make_word(ROTRIGHT), 4'd11, $urandom, $urandom,
                      2'b11, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        $display("[TB] starting randomized sequence");
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 6);
            k   = (sel == 0 || sel == 6) ? NONE : copro_op_e'(3'(sel));
            rdy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom), k, make_word(k), ID_WIDTH'($urandom), $urandom, $urandom,
                          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11, rdy,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
        end

        repeat (DEPTH + 4) idle(1'b1);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/xif_copro_issue_queue.md
# xif_copro_issue_queue

Parametrised issue stage for the XIF coprocessor: decodes each offered instruction, handshakes acceptance with the core, and buffers accepted operations with their operands and instruction ID in a DEPTH-entry FIFO ahead of the execute unit. It is the successor to the purely combinational decoder: XLEN-generic, buffered, back-pressure aware, flushable, and optionally decodes the extended bit-manipulation ops.

## Interface
- XLEN, 32: operand width; power of two, ≥ 8.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- ID_WIDTH, 4: XIF instruction ID width.
- SHW, derived $clog2(XLEN): shift-amount width.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- issue_valid_i  in  1  core offers an instruction.
- issue_ready_o  out  1  issue handshake completes when valid && ready.
- issue_instr_i  in  32  instruction word.
- issue_id_i  in  ID_WIDTH  instruction ID.
- issue_rs_i  in  2×XLEN  source operands rs[0], rs[1].
- issue_rs_valid_i  in  2  per-operand valid.
- issue_accept_o  out  1  instruction is a coprocessor op; valid only during handshake.
- issue_writeback_o  out  1  coprocessor will write rd; equals issue_accept_o.
- flush_i  in  1  discard all queued and in-handshake ops.
- op_valid_o  out  1  head entry valid.
- op_ready_i  in  1  execute unit consumes head.
- op_o  out  3  xif_copro_pkg::copro_op_e of head.
- op_rs0_o  out  XLEN  head rs[0].
- op_rs1_o  out  XLEN  head rs[1], zero-extended from bits [SHW-1:0].
- op_id_o  out  ID_WIDTH  head ID.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Decode: issue_instr_i matched with casez against xif_copro_instr_pkg patterns. BITREV needs rs[0]; ROTRIGHT, ROTLEFT need rs[0], rs[1]. Anything else: not a coprocessor op.
- issue_ready_o, decoded op: !full && all required rs_valid bits set; unused rs valid bits ignored.
- issue_ready_o, non-coprocessor instruction: 1 regardless of full, with issue_accept_o = 0 (immediate reject, no push).
- Push on valid && ready && accept && !flush_i: entry {op, rs[0], rs[1][SHW-1:0] zero-extended, id} written at write pointer.
- Pop on op_valid_o && op_ready_i && !flush_i.
- Pointers are $clog2(DEPTH)+1 bits; wrap at DEPTH with MSB toggle; full = MSBs differ and index bits equal; empty = pointers equal.
- Simultaneous push and pop: count unchanged; allowed when full is false; when full, push blocked (no same-cycle bypass of a freed slot).
- Unused rs[1] for BITREV stored as zero.
- flush_i: pointers and count to 0 next cycle; any same-cycle push or pop discarded; issue_ready_o still follows the rules above so the core sees a completed (discarded) handshake.
- FIFO is first-word-fall-through: head fields driven from storage, not re-registered.

## Timing
- Reset values: issue_ready_o follows combinational rule with empty queue (1 for any request with required rs valid); op_valid_o 0; op_o NONE; op_rs0_o, op_rs1_o, op_id_o 0; count_o 0. Storage contents cleared at reset.
- issue_ready_o, issue_accept_o, issue_writeback_o combinational from issue inputs and full.
- Latency: push in cycle N → op_valid_o high in cycle N+1 with that entry at head if queue was empty.
- Throughput: one push and one pop per cycle.
- op_o/op_rs*/op_id_o stable while op_valid_o && !op_ready_i.
- Reset mid-operation: queue emptied next edge, in-flight handshake discarded.
- When op_valid_o is 0, head outputs are 0.

## Configuration
- XIF_COPRO_EXT_OPS_EN defined: decoder additionally recognises xif_copro_instr_pkg::CLZ and CPOP (rs[0] only, op codes CLZ, CPOP; rs[1] stored as zero); accepted and queued as other ops.
- Undefined: CLZ and CPOP patterns treated as non-coprocessor (ready 1, accept 0); enum values remain reserved, never emitted.

## Test plan
- Reset, then BITREV ID 3, rs0=0x8000_0001, rs_valid=01 → ready=1, accept=1 same cycle; next cycle op_valid_o=1, op_o=BITREV, op_rs0_o=0x8000_0001, op_rs1_o=0, op_id_o=3, count_o=1.
- ROTLEFT with rs_valid=01 → ready=0 until rs_valid=11; then push with rs1=0x0000_0125 → op_rs1_o=0x05 (XLEN=32).
- Fill with 4 ROTRIGHT, op_ready_i=0 → count_o=4, ready=0 for next ROTRIGHT; non-copro word 0x0000_0013 offered → ready=1, accept=0, count stays 4.
- Full queue, op_ready_i=1 and push offered → pop only, count 3; next cycle push+pop → count 3; drain in ID order 0,1,2,3 across pointer wrap.
- Two entries queued, flush_i with simultaneous valid ROTLEFT → count_o=0 and op_valid_o=0 next cycle, flushed op never appears.
- CLZ rs0=0x0000_00FF: with XIF_COPRO_EXT_OPS_EN → accept=1, op_o=CLZ; without → accept=0, no push.
